obstacle_line_scan: RTL and testbench
=====================================

OBSTACLE_LINE_SCAN -- requirements
Module: obstacle_line_scan

Interface
REQ-001 SHALL have parameter MAX_OBSTACLES, default 7, number of obstacle slots scanned per line.
REQ-002 SHALL have parameter GAME_WIDTH, default 640, visible playfield width in pixels.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port line_start  input  1  one-cycle pulse requesting a scan of scanline line_y.
REQ-006 SHALL have port line_y  input  10  scanline index, sampled with line_start.
REQ-007 SHALL have port obstacle_start  input  1 x MAX_OBSTACLES  slot occupied.
REQ-008 SHALL have port obstacle_x_pos  input  signed 11 x MAX_OBSTACLES  left edge.
REQ-009 SHALL have port obstacle_y_pos / obstacle_width / obstacle_height  input  10 x MAX_OBSTACLES each  top edge, size.
REQ-010 SHALL have port obstacle_frame  input  obstacle_pkg::frame_t x MAX_OBSTACLES  sprite frame.
REQ-011 SHALL have port cmd_valid  output  1  draw command valid.
REQ-012 SHALL have port cmd_ready  input  1  downstream blitter accepts command.
REQ-013 SHALL have ports cmd_slot 3, cmd_x_start signed 11, cmd_x_end signed 11, cmd_row 10, cmd_frame frame_t  outputs  command payload.
REQ-014 SHALL have ports busy 1, line_done 1, overrun 1  outputs  scan active, end-of-line pulse, sticky missed-request flag.

Function
REQ-015 SHALL implement states IDLE, SCAN, ISSUE, DONE.
REQ-016 In IDLE, line_start SHALL snapshot line_y and every obstacle_* input into internal registers, clear slot index to 0, and enter SCAN; inputs changing afterwards SHALL NOT affect the current line.
REQ-017 SCAN SHALL evaluate one slot per cycle; hit = start AND y_pos <= line_y < y_pos + height (11-bit unsigned compare) AND horizontal visibility (REQ-024).
REQ-018 On hit, SCAN SHALL load payload registers and enter ISSUE; cmd_valid SHALL assert the following cycle; on miss, index increments, or after slot MAX_OBSTACLES-1 enter DONE.
REQ-019 In ISSUE, cmd_valid and payload SHALL remain stable until the cycle cmd_valid AND cmd_ready; then cmd_valid deasserts, state returns to SCAN at index+1, or DONE if index was last.
REQ-020 Payload: cmd_slot = index; cmd_row = line_y - y_pos; cmd_frame = snapshotted frame; commands SHALL be issued in ascending slot order.
REQ-021 DONE SHALL assert line_done for exactly one cycle and return to IDLE; busy = 1 in SCAN, ISSUE, DONE.
REQ-022 line_start while not IDLE SHALL be ignored and set overrun to 1; overrun clears only on reset.
REQ-023 Line with no hits, cmd_ready held high: line_done SHALL occur MAX_OBSTACLES+1 cycles after line_start; each hit adds 1 cycle plus back-pressure stall cycles.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, index 0, cmd_valid 0, busy 0, line_done 0, overrun 0, payload registers 0; a pending command SHALL be dropped with no handshake.
REQ-026 After rst deasserts, first line_start SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-024 Macro OBSTACLE_LINE_SCAN_CLIP_EN: defined -> hit additionally requires x_pos + width > 0 and x_pos < GAME_WIDTH (12-bit signed), cmd_x_start = max(x_pos,0), cmd_x_end = min(x_pos+width, GAME_WIDTH) - 1; undefined -> no horizontal test, cmd_x_start = x_pos, cmd_x_end = x_pos + width - 1 unclipped.

Verification
REQ-027 Slot 2 start=1, x=100, y=90, w=20, h=30; line_y=100, ready=1 -> one command slot 2, x 100..119, row 10; line_done 9 cycles after line_start.
REQ-028 Slots 0 and 5 hit, cmd_ready low 4 cycles after first valid -> payload stable throughout, slot 0 then slot 5, no command lost or duplicated.
REQ-029 CLIP_EN defined: x=-10, w=25 -> x 0..14; x=630, w=25 -> x 630..639; x=-30, w=25 -> no command; CLIP_EN undefined: x=-30 -> command x -30..-6.
REQ-030 Boundaries: line_y = y_pos + height - 1 -> hit; line_y = y_pos + height -> miss; start=0 with matching geometry -> miss.
REQ-031 line_start during ISSUE -> ignored, overrun = 1 and stays; rst low mid-ISSUE -> cmd_valid 0 immediately, IDLE, overrun 0.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types for the obstacle scanline engine: sprite frame index and scan FSM state encoding.
package obstacle_pkg;

    typedef logic [3:0] frame_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/obstacle_line_scan_if.sv
// Draw-command channel from the scanline engine to the blitter.
// Handshake: cmd_valid/payload held stable until the cycle with cmd_valid && cmd_ready; that cycle transfers exactly one command.
interface obstacle_line_scan_if;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_slot;
    logic signed [10:0]    cmd_x_start;
    logic signed [10:0]    cmd_x_end;
    logic [9:0]            cmd_row;
    obstacle_pkg::frame_t  cmd_frame;

    modport master (
        output cmd_valid, cmd_slot, cmd_x_start, cmd_x_end, cmd_row, cmd_frame,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_slot, cmd_x_start, cmd_x_end, cmd_row, cmd_frame,
        output cmd_ready
    );
endinterface

// File: rtl/obstacle_line_scan.sv
// Per-scanline obstacle scanner: snapshots obstacle slots, tests one slot per cycle, issues draw commands in slot order.
// Optional horizontal clipping to the playfield is enabled by defining OBSTACLE_LINE_SCAN_CLIP_EN.
module obstacle_line_scan
    import obstacle_pkg::*;
#(
    parameter int MAX_OBSTACLES = 7,
    parameter int GAME_WIDTH    = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_start,
    input  logic [9:0]               line_y,
    input  logic [MAX_OBSTACLES-1:0] obstacle_start,
    input  logic signed [10:0]       obstacle_x_pos  [MAX_OBSTACLES],
    input  logic [9:0]               obstacle_y_pos  [MAX_OBSTACLES],
    input  logic [9:0]               obstacle_width  [MAX_OBSTACLES],
    input  logic [9:0]               obstacle_height [MAX_OBSTACLES],
    input  frame_t                   obstacle_frame  [MAX_OBSTACLES],
    obstacle_line_scan_if.master     cmd,
    output logic                     busy,
    output logic                     line_done,
    output logic                     overrun,
    output scan_state_e              dbg_state
);

    localparam logic [2:0] LAST = 3'(MAX_OBSTACLES - 1);

    scan_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [9:0]  line_y_q;
    logic [MAX_OBSTACLES-1:0] snap_start_q;
    logic signed [10:0] snap_x_q [MAX_OBSTACLES];
    logic [9:0]  snap_y_q [MAX_OBSTACLES];
    logic [9:0]  snap_w_q [MAX_OBSTACLES];
    logic [9:0]  snap_h_q [MAX_OBSTACLES];
    frame_t      snap_f_q [MAX_OBSTACLES];

    logic [2:0]         slot_q;
    logic signed [10:0] xs_q, xe_q;
    logic [9:0]         row_q;
    frame_t             frame_q;
    logic               overrun_q;

    logic               accept;
    logic               hit, hit_y, hit_x;
    logic [10:0]        y_lo, y_hi, ly;
    logic signed [10:0] xs_c, xe_c;

    assign accept = (state_q == ST_IDLE) && line_start;

    // Vertical test widened to 11 bits so y_pos + height cannot wrap.
    always_comb begin
        ly    = {1'b0, line_y_q};
        y_lo  = {1'b0, snap_y_q[idx_q]};
        y_hi  = {1'b0, snap_y_q[idx_q]} + {1'b0, snap_h_q[idx_q]};
        hit_y = (ly >= y_lo) && (ly < y_hi);
    end

`ifdef OBSTACLE_LINE_SCAN_CLIP_EN
    localparam logic signed [11:0] GW12 = 12'(GAME_WIDTH);
    logic signed [11:0] x12, r12, xe12;
    always_comb begin
        x12   = {snap_x_q[idx_q][10], snap_x_q[idx_q]};
        r12   = x12 + $signed({2'b00, snap_w_q[idx_q]});
        hit_x = (r12 > 12'sd0) && (x12 < GW12);
        xs_c  = snap_x_q[idx_q][10] ? 11'sd0 : snap_x_q[idx_q];
        xe12  = ((r12 > GW12) ? GW12 : r12) - 12'sd1;
        xe_c  = xe12[10:0];
    end
`else
    always_comb begin
        hit_x = 1'b1;
        xs_c  = snap_x_q[idx_q];
        xe_c  = snap_x_q[idx_q] + $signed({1'b0, snap_w_q[idx_q]}) - 11'sd1;
    end
`endif

    assign hit = snap_start_q[idx_q] && hit_y && hit_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: if (line_start) begin
                state_d = ST_SCAN;
                idx_d   = '0;
            end
            ST_SCAN: begin
                if (hit)                 state_d = ST_ISSUE;
                else if (idx_q == LAST)  state_d = ST_DONE;
                else                     idx_d   = idx_q + 3'd1;
            end
            ST_ISSUE: if (cmd.cmd_ready) begin
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                    idx_d   = idx_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        line_done     = (state_q == ST_DONE);
        cmd.cmd_valid = (state_q == ST_ISSUE);
    end

    // Snapshot, payload and sticky overrun registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_y_q     <= '0;
            snap_start_q <= '0;
            snap_x_q     <= '{default: '0};
            snap_y_q     <= '{default: '0};
            snap_w_q     <= '{default: '0};
            snap_h_q     <= '{default: '0};
            snap_f_q     <= '{default: '0};
            slot_q       <= '0;
            xs_q         <= '0;
            xe_q         <= '0;
            row_q        <= '0;
            frame_q      <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (accept) begin
                line_y_q     <= line_y;
                snap_start_q <= obstacle_start;
                snap_x_q     <= obstacle_x_pos;
                snap_y_q     <= obstacle_y_pos;
                snap_w_q     <= obstacle_width;
                snap_h_q     <= obstacle_height;
                snap_f_q     <= obstacle_frame;
            end
            if (state_q == ST_SCAN && hit) begin
                slot_q  <= idx_q;
                xs_q    <= xs_c;
                xe_q    <= xe_c;
                row_q   <= line_y_q - snap_y_q[idx_q];
                frame_q <= snap_f_q[idx_q];
            end
            if (line_start && state_q != ST_IDLE) overrun_q <= 1'b1;
        end
    end

    assign cmd.cmd_slot    = slot_q;
    assign cmd.cmd_x_start = xs_q;
    assign cmd.cmd_x_end   = xe_q;
    assign cmd.cmd_row     = row_q;
    assign cmd.cmd_frame   = frame_q;
    assign overrun         = overrun_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_obstacle_line_scan.sv
// Directed bench for obstacle_line_scan: hand-computed commands in an expected queue, line_done latency and overrun/reset checks.
module tb_obstacle_line_scan;
    import obstacle_pkg::*;

    localparam int N = 7;

    logic clk = 1'b0;
    logic rst;
    logic line_start;
    logic [9:0] line_y;
    logic [N-1:0] obstacle_start;
    logic signed [10:0] obstacle_x_pos [N];
    logic [9:0] obstacle_y_pos [N];
    logic [9:0] obstacle_width [N];
    logic [9:0] obstacle_height [N];
    frame_t obstacle_frame [N];
    logic busy, line_done, overrun;
    scan_state_e dbg_state;

    obstacle_line_scan_if cmd_if ();

    obstacle_line_scan #(.MAX_OBSTACLES(N), .GAME_WIDTH(640)) dut (
        .clk             (clk),
        .rst             (rst),
        .line_start      (line_start),
        .line_y          (line_y),
        .obstacle_start  (obstacle_start),
        .obstacle_x_pos  (obstacle_x_pos),
        .obstacle_y_pos  (obstacle_y_pos),
        .obstacle_width  (obstacle_width),
        .obstacle_height (obstacle_height),
        .obstacle_frame  (obstacle_frame),
        .cmd             (cmd_if),
        .busy            (busy),
        .line_done       (line_done),
        .overrun         (overrun),
        .dbg_state       (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cyc = 0;
    int stall_left = 0;
    logic [38:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [38:0] pack(input int slot, input int xs, input int xe, input int row, input int fr);
        return {3'(slot), 11'(xs), 11'(xe), 10'(row), 4'(fr)};
    endfunction

    logic [38:0] obs;
    assign obs = {cmd_if.cmd_slot, cmd_if.cmd_x_start, cmd_if.cmd_x_end, cmd_if.cmd_row, cmd_if.cmd_frame};

    // Back-pressure driver: holds ready low for stall_left cycles of valid
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && cmd_if.cmd_valid) begin
            cmd_if.cmd_ready = 1'b0;
            stall_left--;
        end else begin
            cmd_if.cmd_ready = 1'b1;
        end
    end

    // Scoreboard: compare each handshake with the queue head, payload must hold while stalled
    logic [38:0] prev;
    bit have_prev = 0;
    always @(posedge clk) begin
        if (rst && cmd_if.cmd_valid) begin
            if (have_prev) check("payload_hold", obs, prev);
            if (cmd_if.cmd_ready) begin
                if (exp_q.size() == 0) check("unexpected_cmd", exp_q.size(), 1);
                else check("cmd", obs, exp_q.pop_front());
                have_prev = 0;
            end else begin
                prev = obs;
                have_prev = 1;
            end
        end else begin
            have_prev = 0;
        end
    end

    // Driver tasks
    task automatic clear_obs();
        obstacle_start = '0;
        for (int i = 0; i < N; i++) begin
            obstacle_x_pos[i]  = '0;
            obstacle_y_pos[i]  = '0;
            obstacle_width[i]  = '0;
            obstacle_height[i] = '0;
            obstacle_frame[i]  = '0;
        end
    endtask

    task automatic set_obs(input int s, input int x, input int y, input int w, input int h, input int fr);
        obstacle_start[s]  = 1'b1;
        obstacle_x_pos[s]  = 11'(x);
        obstacle_y_pos[s]  = 10'(y);
        obstacle_width[s]  = 10'(w);
        obstacle_height[s] = 10'(h);
        obstacle_frame[s]  = 4'(fr);
    endtask

    task automatic start_line(input int ly);
        @(posedge clk);
        #1;
        line_y = 10'(ly);
        line_start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        line_start = 1'b0;
        line_y = 10'($urandom_range(0, 1023));
    endtask

    task automatic wait_done(input int exp_lat);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (line_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'(seen), 1);
        else check("latency", cyc - start_cyc, exp_lat);
        @(negedge clk);
        check("done_pulse", line_done, 0);
        check("idle_busy", busy, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        line_start = 1'b0;
        line_y = '0;
        cmd_if.cmd_ready = 1'b1;
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_valid", cmd_if.cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", line_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_payload", obs, 0);
        #2 rst = 1'b1;

        // Single hit on slot 2; inputs scrambled after line_start must not matter
        set_obs(2, 100, 90, 20, 30, 3);
        exp_q.push_back(pack(2, 100, 119, 10, 3));
        start_line(100);
        obstacle_start[2] = 1'b0;
        obstacle_y_pos[2] = 10'd500;
        wait_done(9);
        check("overrun_quiet", overrun, 0);

        // Slots 0 and 5 with 4 cycles of back-pressure on the first command
        clear_obs();
        set_obs(0, 0, 0, 10, 50, 1);
        set_obs(5, 300, 40, 5, 20, 7);
        exp_q.push_back(pack(0, 0, 9, 45, 1));
        exp_q.push_back(pack(5, 300, 304, 5, 7));
        stall_left = 4;
        start_line(45);
        wait_done(14);

        // Vertical boundaries and unoccupied slot
        clear_obs();
        set_obs(1, 50, 200, 8, 10, 9);
        exp_q.push_back(pack(1, 50, 57, 9, 9));
        start_line(209);
        wait_done(9);
        start_line(210);
        wait_done(8);
        obstacle_start[1] = 1'b0;
        start_line(205);
        wait_done(8);

        // Horizontal edges
        clear_obs();
        set_obs(0, -10, 0, 25, 10, 2);
        set_obs(3, 630, 0, 25, 10, 4);
        set_obs(4, -30, 0, 25, 10, 6);
`ifdef OBSTACLE_LINE_SCAN_CLIP_EN
        exp_q.push_back(pack(0, 0, 14, 5, 2));
        exp_q.push_back(pack(3, 630, 639, 5, 4));
        start_line(5);
        wait_done(10);
`else
        exp_q.push_back(pack(0, -10, 14, 5, 2));
        exp_q.push_back(pack(3, 630, 654, 5, 4));
        exp_q.push_back(pack(4, -30, -6, 5, 6));
        start_line(5);
        wait_done(11);
`endif

        // line_start during ISSUE, then reset with a command pending
        clear_obs();
        set_obs(0, 5, 0, 4, 4, 5);
        exp_q.push_back(pack(0, 5, 8, 2, 5));
        stall_left = 1000;
        start_line(2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_if.cmd_valid) break;
        end
        check("valid_seen", cmd_if.cmd_valid, 1);
        @(posedge clk);
        #1 line_start = 1'b1;
        @(posedge clk);
        #1 line_start = 1'b0;
        @(negedge clk);
        check("overrun_set", overrun, 1);
        check("still_issue", dbg_state, ST_ISSUE);
        check("pending_payload", obs, pack(0, 5, 8, 2, 5));
        repeat (3) @(negedge clk);
        check("overrun_sticky", overrun, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_valid", cmd_if.cmd_valid, 0);
        check("rst_async_state", dbg_state, ST_IDLE);
        check("rst_async_overrun", overrun, 0);
        check("rst_async_busy", busy, 0);
        exp_q.delete();
        stall_left = 0;
        @(negedge clk);
        #2 rst = 1'b1;

        // Normal operation resumes after reset
        exp_q.push_back(pack(0, 5, 8, 3, 5));
        start_line(3);
        wait_done(9);
        check("overrun_after", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
